// File: rtl/rx_window_sequencer_pkg.sv
// Shared types for the receive window sequencer: state encoding, counter
// width and the double-buffered configuration record.
package rx_window_sequencer_pkg;

   localparam int unsigned CNT_W  = 16;
   localparam int unsigned SPAN_W = CNT_W + 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_WIN  = 2'd2,
      ST_HOLD = 2'd3
   } seq_state_e;

   typedef struct packed {
      logic [CNT_W-1:0] ipp;
      logic [CNT_W-1:0] start;
      logic [CNT_W-1:0] len;
   } win_cfg_t;

   // Window must be non-empty and fit inside the IPP; sum is one bit wider so it cannot wrap.
   function automatic logic cfg_is_valid(input win_cfg_t cfg);
      logic [SPAN_W-1:0] span;
      span = SPAN_W'(cfg.start) + SPAN_W'(cfg.len);
      return (cfg.ipp != '0) && (cfg.len != '0) && (span <= SPAN_W'(cfg.ipp));
   endfunction

endpackage

// File: rtl/rx_window_sequencer_if.sv
// Control/status bundle between the sampling datapath and the window sequencer.
interface rx_window_sequencer_if;
   import rx_window_sequencer_pkg::*;

   logic             run;
   logic             strobe;
   logic [CNT_W-1:0] cfg_ipp;
   logic [CNT_W-1:0] cfg_start;
   logic [CNT_W-1:0] cfg_len;
   logic             cfg_load;
   logic             cfg_ack;
   logic             cfg_err;
   logic             window;
   logic             tag;
   logic             sample_strobe;
   logic             ipp_start;
   logic             busy;

   modport master (
      output run, strobe, cfg_ipp, cfg_start, cfg_len, cfg_load,
      input  cfg_ack, cfg_err, window, tag, sample_strobe, ipp_start, busy
   );

   modport slave (
      input  run, strobe, cfg_ipp, cfg_start, cfg_len, cfg_load,
      output cfg_ack, cfg_err, window, tag, sample_strobe, ipp_start, busy
   );

endinterface

// File: rtl/rx_cfg_shadow.sv
// Validates incoming window configs and holds the pending/active pair; the
// pending copy is promoted only when the sequencer grants an apply point.
module rx_cfg_shadow
   import rx_window_sequencer_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             load_i,
   input  win_cfg_t         cfg_i,
   input  logic             apply_ok_i,
   output win_cfg_t         active_o,
   output logic             active_valid_o,
   output logic             pending_valid_o,
   output logic [CNT_W-1:0] next_start_o,
   output logic             ack_o,
   output logic             err_o
);

   win_cfg_t pending_q;
   win_cfg_t active_q;
   logic     pending_valid_q;
   logic     ack_q;
   logic     err_q;
   logic     cfg_ok;
   logic     accept;
   logic     apply;

   assign cfg_ok = cfg_is_valid(cfg_i);
   assign accept = load_i && cfg_ok;
   assign apply  = pending_valid_q && apply_ok_i;

   // A load landing on an apply cycle stays pending for the following boundary.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending_q       <= '0;
         active_q        <= '0;
         pending_valid_q <= 1'b0;
         ack_q           <= 1'b0;
         err_q           <= 1'b0;
      end else begin
         err_q <= load_i && !cfg_ok;
         ack_q <= apply;
         if (apply) begin
            active_q <= pending_q;
         end
         if (accept) begin
            pending_q       <= cfg_i;
            pending_valid_q <= 1'b1;
         end else if (apply) begin
            pending_valid_q <= 1'b0;
         end
      end
   end

   assign active_o        = active_q;
   assign active_valid_o  = active_q.ipp != '0;
   assign pending_valid_o = pending_valid_q;
   assign next_start_o    = pending_valid_q ? pending_q.start : active_q.start;
   assign ack_o           = ack_q;
   assign err_o           = err_q;

endmodule

// File: rtl/rx_window_sequencer.sv
// Counts sample strobes over each inter-pulse period and emits the receive
// window level, start-of-window tag, gated strobe and IPP start marker.
module rx_window_sequencer
   import rx_window_sequencer_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   rx_window_sequencer_if.slave rx
);

   win_cfg_t         cfg_in;
   win_cfg_t         active;
   logic             active_valid;
   logic             pending_valid;
   logic             apply_ok;
   logic [CNT_W-1:0] next_start;
   logic [CNT_W-1:0] last_idx;

   seq_state_e       state_q;
   seq_state_e       wrap_state;
   logic [CNT_W-1:0] idx_q;
   logic             window_q;
   logic             tag_q;
   logic             sstrb_q;
   logic             ipp_start_q;
   logic             busy_q;

   logic             running;
   logic             stb_run;
   logic             at_first;
   logic             at_last;
   logic             at_wrap;
   logic             in_win;

   assign cfg_in = '{ipp: rx.cfg_ipp, start: rx.cfg_start, len: rx.cfg_len};

   rx_cfg_shadow u_shadow (
      .clk             (clk),
      .reset           (reset),
      .load_i          (rx.cfg_load),
      .cfg_i           (cfg_in),
      .apply_ok_i      (apply_ok),
      .active_o        (active),
      .active_valid_o  (active_valid),
      .pending_valid_o (pending_valid),
      .next_start_o    (next_start),
      .ack_o           (rx.cfg_ack),
      .err_o           (rx.cfg_err)
   );

   assign running  = state_q != ST_IDLE;
   assign stb_run  = rx.strobe && running;
   assign last_idx = active.start + active.len - CNT_W'(1);
   assign at_first = idx_q == active.start;
   assign at_last  = idx_q == last_idx;
   assign at_wrap  = idx_q == (active.ipp - CNT_W'(1));
   assign in_win   = ((state_q == ST_WAIT) && at_first) || (state_q == ST_WIN);

   // Config may only change while idle or on the strobe that closes an IPP.
   assign apply_ok = !running || (rx.strobe && at_wrap);

   // The next IPP follows the config that becomes active on this wrap.
   assign wrap_state = !rx.run ? ST_IDLE : ((next_start == '0) ? ST_WIN : ST_WAIT);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         window_q    <= 1'b0;
         tag_q       <= 1'b0;
         sstrb_q     <= 1'b0;
         ipp_start_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         tag_q       <= 1'b0;
         sstrb_q     <= 1'b0;
         ipp_start_q <= 1'b0;

         // Window level tracks whether the most recent strobe was an in-window sample.
         if (rx.strobe) begin
            window_q <= running && in_win;
         end
         if (stb_run) begin
            sstrb_q     <= in_win;
            tag_q       <= in_win && at_first;
            ipp_start_q <= idx_q == '0;
            idx_q       <= at_wrap ? '0 : idx_q + CNT_W'(1);
         end

         case (state_q)
            ST_IDLE: begin
               if (rx.run && active_valid && !pending_valid) begin
                  state_q <= (active.start == '0) ? ST_WIN : ST_WAIT;
                  busy_q  <= 1'b1;
                  idx_q   <= '0;
               end
            end
            ST_WAIT: begin
               if (rx.strobe && at_first) begin
                  if (at_last && at_wrap) begin
                     state_q <= wrap_state;
                     busy_q  <= rx.run;
                  end else if (at_last) begin
                     state_q <= ST_HOLD;
                  end else begin
                     state_q <= ST_WIN;
                  end
               end
            end
            ST_WIN: begin
               if (rx.strobe && at_last) begin
                  if (at_wrap) begin
                     state_q <= wrap_state;
                     busy_q  <= rx.run;
                  end else begin
                     state_q <= ST_HOLD;
                  end
               end
            end
            ST_HOLD: begin
               if (rx.strobe && at_wrap) begin
                  state_q <= wrap_state;
                  busy_q  <= rx.run;
               end
            end
         endcase
      end
   end

   assign rx.window        = window_q;
   assign rx.tag           = tag_q;
   assign rx.sample_strobe = sstrb_q;
   assign rx.ipp_start     = ipp_start_q;
   assign rx.busy          = busy_q;

endmodule

// File: tb/tb_rx_window_sequencer.sv
// Self-checking bench for rx_window_sequencer: directed scenarios followed by
// randomized traffic, all compared against a sample-index reference model.
module tb_rx_window_sequencer;
   import rx_window_sequencer_pkg::*;

   logic clk = 1'b0;
   logic reset;

   rx_window_sequencer_if rx ();

   rx_window_sequencer dut (
      .clk   (clk),
      .reset (reset),
      .rx    (rx)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int gcyc     = 0;

   // Reference model: sample index, run flag, active/pending configs, expected outputs.
   bit m_act;
   int m_idx;
   int a_ipp, a_st, a_len;
   bit p_v;
   int p_ipp, p_st, p_len;
   bit e_win, e_tag, e_ss, e_ipp, e_ack, e_err;

   task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic logic [6:0] dut_vec();
      return {rx.busy, rx.window, rx.tag, rx.sample_strobe, rx.ipp_start, rx.cfg_ack, rx.cfg_err};
   endfunction

   function automatic logic [6:0] exp_vec();
      return {m_act, e_win, e_tag, e_ss, e_ipp, e_ack, e_err};
   endfunction

   function automatic void model_reset();
      m_act = 1'b0; m_idx = 0;
      a_ipp = 0; a_st = 0; a_len = 0;
      p_v = 1'b0; p_ipp = 0; p_st = 0; p_len = 0;
      e_win = 1'b0; e_tag = 1'b0; e_ss = 1'b0; e_ipp = 1'b0; e_ack = 1'b0; e_err = 1'b0;
   endfunction

   // One clock of behaviour, from the inputs present at this edge.
   function automatic void model_step();
      int  ci, cs, cl;
      bit  stb, wrap, apply, start_now, member;
      ci  = int'(rx.cfg_ipp);
      cs  = int'(rx.cfg_start);
      cl  = int'(rx.cfg_len);
      stb = rx.strobe;
      wrap      = m_act && stb && (m_idx == a_ipp - 1);
      apply     = p_v && (!m_act || wrap);
      start_now = !m_act && rx.run && (a_ipp != 0) && !p_v;
      e_err = rx.cfg_load && !((ci != 0) && (cl != 0) && (cs + cl <= ci));
      e_ack = apply;
      e_tag = 1'b0; e_ss = 1'b0; e_ipp = 1'b0;
      if (stb) begin
         if (m_act) begin
            member = (m_idx >= a_st) && (m_idx < a_st + a_len);
            e_ss  = member;
            e_tag = member && (m_idx == a_st);
            e_ipp = (m_idx == 0);
            e_win = member;
            if (wrap) begin
               m_idx = 0;
               if (!rx.run) m_act = 1'b0;
            end else begin
               m_idx = m_idx + 1;
            end
         end else begin
            e_win = 1'b0;
         end
      end
      if (start_now) begin
         m_act = 1'b1;
         m_idx = 0;
      end
      if (apply) begin
         a_ipp = p_ipp; a_st = p_st; a_len = p_len;
      end
      if (rx.cfg_load && !e_err) begin
         p_v = 1'b1; p_ipp = ci; p_st = cs; p_len = cl;
      end else if (apply) begin
         p_v = 1'b0;
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      if (reset) model_reset();
      else model_step();
      gcyc++;
      #1;
      check_eq("outs", 32'(dut_vec()), 32'(exp_vec()));
      rx.cfg_load = 1'b0;
   endtask

   task automatic drive(input int period);
      rx.strobe = ((gcyc % period) == 0);
      tick();
   endtask

   task automatic load_cfg(input int ipp, input int st, input int len);
      rx.cfg_ipp   = CNT_W'(ipp);
      rx.cfg_start = CNT_W'(st);
      rx.cfg_len   = CNT_W'(len);
      rx.cfg_load  = 1'b1;
   endtask

   // Reset applied between clock edges; outputs must clear without waiting for an edge.
   task automatic do_reset();
      reset = 1'b1;
      #1;
      model_reset();
      check_eq("rst_async", 32'(dut_vec()), 32'(exp_vec()));
   endtask

   initial begin
      bit hit;
      reset        = 1'b1;
      rx.run       = 1'b0;
      rx.strobe    = 1'b0;
      rx.cfg_load  = 1'b0;
      rx.cfg_ipp   = '0;
      rx.cfg_start = '0;
      rx.cfg_len   = '0;
      model_reset();
      repeat (3) tick();
      reset = 1'b0;
      check_eq("post_rst", 32'(dut_vec()), 32'(0));

      // Basic windowing, slow strobe.
      load_cfg(10, 2, 3);
      rx.run = 1'b1;
      repeat (2700) drive(64);

      // Rejected config must leave the running one untouched.
      load_cfg(10, 8, 3);
      repeat (700) drive(64);

      // Reload in the middle of a window.
      hit = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         if (e_win && m_idx == 4) begin hit = 1'b1; break; end
         drive(64);
      end
      check_eq("wait_mid_win", 32'(hit), 32'(1));
      load_cfg(20, 5, 4);
      repeat (1500) drive(16);

      // Window spanning whole IPP.
      load_cfg(10, 0, 10);
      repeat (1000) drive(8);

      // Stop mid-IPP after idx 3.
      load_cfg(10, 2, 3);
      hit = 1'b0;
      for (int i = 0; i < 600; i++) begin
         if (m_act && !p_v && a_st == 2 && a_ipp == 10 && m_idx == 4) begin hit = 1'b1; break; end
         drive(8);
      end
      check_eq("wait_idx4", 32'(hit), 32'(1));
      rx.run = 1'b0;
      repeat (300) drive(8);
      check_eq("busy_stop", 32'(rx.busy), 32'(0));

      // Reset during a window.
      rx.run = 1'b1;
      hit = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (e_win) begin hit = 1'b1; break; end
         drive(8);
      end
      check_eq("wait_win_rst", 32'(hit), 32'(1));
      do_reset();
      repeat (2) drive(8);
      reset = 1'b0;
      load_cfg(10, 2, 3);
      repeat (400) drive(8);

      // Randomized traffic.
      for (int i = 0; i < 20000; i++) begin
         if ($urandom_range(0, 149) == 0) rx.run = ~rx.run;
         if ($urandom_range(0, 39) == 0)
            load_cfg(int'($urandom_range(0, 12)), int'($urandom_range(0, 12)),
                     int'($urandom_range(0, 12)));
         if ($urandom_range(0, 4999) == 0) begin
            do_reset();
            rx.strobe = 1'b0;
            tick();
            reset = 1'b0;
         end
         rx.strobe = ($urandom_range(0, 2) == 0);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
